axi_req_fifo_drain: RTL and testbench

- Read-side companion to the AXI request FIFO: pops requests out of a `sync_fifo` instance through its `ren`/`dout`/`empty` port.
- Presents the popped requests on an AXI-style valid/ready master channel (AR, AW or W payload).
- Hides the FIFO's one-cycle registered read latency behind a 2-entry output buffer, sustaining one beat per cycle under continuous `m_ready`.
- Sits between each channel's request FIFO and the downstream interconnect/memory port.

---
 rtl/axi_drain_pkg.sv | 17 +
 rtl/axi_drain_skid_buf.sv | 64 ++++++
 rtl/axi_req_fifo_drain.sv | 83 ++++++++
 tb/tb_axi_req_fifo_drain.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_drain_pkg.sv
// Shared types and constants for the AXI request FIFO drain block.
// Buffer occupancy states, statistics counter width and a saturating increment helper.
package axi_drain_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    localparam int unsigned STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/axi_drain_skid_buf.sv
// Two-entry head/tail output buffer for the FIFO drain.
// The occupancy FSM state doubles as the occ count presented to the credit logic.
module axi_drain_skid_buf
    import axi_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);

    occ_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (pop) begin
            head_d = tail_q;
        end
        // Capture lands in whichever slot is the first free one once the pop is applied.
        if (capture) begin
            if (state_q == ST_EMPTY || (state_q == ST_ONE && pop)) begin
                head_d = cap_data;
            end else begin
                tail_d = cap_data;
            end
        end

        unique case (state_q)
            ST_EMPTY: if (capture)             state_d = ST_ONE;
            ST_ONE: begin
                if (capture && !pop)           state_d = ST_FULL;
                else if (!capture && pop)      state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop && !capture)     state_d = ST_ONE;
            default:                           state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign occ  = state_q;
    assign head = head_q;

endmodule

// File: rtl/axi_req_fifo_drain.sv
// Pops requests from a sync_fifo and presents them on a valid/ready master channel.
// Optional beat/stall statistics are enabled with the AXI_DRAIN_STATS_EN macro.
module axi_req_fifo_drain
    import axi_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef AXI_DRAIN_STATS_EN
    ,
    output logic [STAT_W-1:0]     beat_cnt,
    output logic [STAT_W-1:0]     stall_cnt
`endif
);

    logic       inflight_q, inflight_d;
    logic [1:0] occ;
    logic       pop;
    logic [2:0] credit;

    axi_drain_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk      (clk),
        .rst      (rst),
        .capture  (inflight_q),
        .cap_data (fifo_dout),
        .pop      (pop),
        .occ      (occ),
        .head     (m_data)
    );

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;

    // Slots committed after this cycle; pop never exceeds occ, so no wrap.
    always_comb begin
        credit     = 3'(occ) + 3'(inflight_q) - 3'(pop);
        fifo_ren   = !rst && !fifo_empty && (credit < 3'd2);
        inflight_d = fifo_ren;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

`ifdef AXI_DRAIN_STATS_EN
    logic [STAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop)                  beat_cnt_d  = sat_inc(beat_cnt_q);
        if (m_valid && !m_ready)  stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi_req_fifo_drain.sv
// Directed self-checking bench for axi_req_fifo_drain with a registered-read FIFO model.
// Stats checks are active when AXI_DRAIN_STATS_EN is defined.
module tb_axi_req_fifo_drain;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_ren;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef AXI_DRAIN_STATS_EN
    logic [15:0]   beat_cnt;
    logic [15:0]   stall_cnt;
`endif

    logic [DW-1:0] mem [0:15];
    int            wr_ptr;
    int            rd_ptr;
    int            tests;
    int            fails;

    always #5 clk = ~clk;

    axi_req_fifo_drain #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef AXI_DRAIN_STATS_EN
        ,
        .beat_cnt   (beat_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    // sync_fifo model: one-cycle registered read, shares the DUT reset.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 0;
        end else if (fifo_ren && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic do_reset();
        rst     = 1'b1;
        m_ready = 1'b0;
        wr_ptr  = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) mem[i] = base + DW'(i);
        wr_ptr = n;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        m_ready = 1'b1;
        wr_ptr  = 0;
        @(posedge clk); #1;
        load(32'h55, 2);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if (fifo_ren !== 1'b0) begin
                fails++; $display("FAIL reset_ren: got %b want 0", fifo_ren);
            end
            tests++;
            if (m_valid !== 1'b0) begin
                fails++; $display("FAIL reset_valid: got %b want 0", m_valid);
            end
            tests++;
            if (m_data !== 32'h0) begin
                fails++; $display("FAIL reset_data: got %h want 0", m_data);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fill_drain();
        int first_ren = -1, first_valid = -1, last_pop = -1, k = 0, bad_ren = 0;
        do_reset();
        load(32'hA0, 4);
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            @(negedge clk);
            if (fifo_ren && fifo_empty) bad_ren++;
            if (fifo_ren && first_ren < 0) first_ren = cyc;
            if (m_valid) begin
                if (first_valid < 0) first_valid = cyc;
                tests++;
                if (m_data !== 32'hA0 + DW'(k)) begin
                    fails++; $display("FAIL fill_data[%0d]: got %h want %h", k, m_data, 32'hA0 + DW'(k));
                end
                last_pop = cyc;
                k++;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (k != 4) begin
            fails++; $display("FAIL fill_count: got %0d want 4", k);
        end
        tests++;
        if (first_valid - first_ren != 2) begin
            fails++; $display("FAIL fill_latency: got %0d want 2", first_valid - first_ren);
        end
        tests++;
        if (last_pop - first_valid != 3) begin
            fails++; $display("FAIL fill_consecutive: got span %0d want 3", last_pop - first_valid);
        end
        tests++;
        if (bad_ren != 0) begin
            fails++; $display("FAIL fill_ren_empty: got %0d want 0", bad_ren);
        end
    endtask

    task automatic test_backpressure();
        int ren_cnt = 0, stalls = 0, k = 0, hold_bad = 0, ren_at_release = -1;
        do_reset();
        load(32'hA0, 4);
        m_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            if (fifo_ren) ren_cnt++;
            if (m_valid && !m_ready) begin
                stalls++;
                if (m_data !== 32'hA0) hold_bad++;
            end
            if (m_valid && m_ready) begin
                tests++;
                if (m_data !== 32'hA0 + DW'(k)) begin
                    fails++; $display("FAIL bp_data[%0d]: got %h want %h", k, m_data, 32'hA0 + DW'(k));
                end
                k++;
            end
            @(posedge clk); #1;
            if (!m_ready && stalls == 5) begin
                ren_at_release = ren_cnt;
                m_ready = 1'b1;
            end
        end
        tests++;
        if (ren_at_release != 2) begin
            fails++; $display("FAIL bp_ren_before_stall: got %0d want 2", ren_at_release);
        end
        tests++;
        if (hold_bad != 0) begin
            fails++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad);
        end
        tests++;
        if (k != 4) begin
            fails++; $display("FAIL bp_count: got %0d want 4", k);
        end
        tests++;
        if (ren_cnt != 4) begin
            fails++; $display("FAIL bp_ren_total: got %0d want 4", ren_cnt);
        end
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0) begin
            fails++; $display("FAIL bp_drained: got %b want 0", m_valid);
        end
`ifdef AXI_DRAIN_STATS_EN
        tests++;
        if (beat_cnt !== 16'd4) begin
            fails++; $display("FAIL stats_beat: got %0d want 4", beat_cnt);
        end
        tests++;
        if (stall_cnt !== 16'd5) begin
            fails++; $display("FAIL stats_stall: got %0d want 5", stall_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_empty_fifo();
        do_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tests++;
            if (fifo_ren !== 1'b0 || m_valid !== 1'b0) begin
                fails++; $display("FAIL empty_idle[%0d]: got ren=%b valid=%b want 0/0", c, fifo_ren, m_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int k = 0;
        do_reset();
        load(32'hA0, 4);
        m_ready = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (m_valid) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL rstmid_fill: got no m_valid want m_valid");
        end
        // One beat buffered and one FIFO read in flight here.
        rst     = 1'b1;
        m_ready = 1'b1;
        wr_ptr  = 0;
        @(negedge clk);
        tests++;
        if (fifo_ren !== 1'b0) begin
            fails++; $display("FAIL rstmid_ren_in_rst: got %b want 0", fifo_ren);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || m_data !== 32'h0 || fifo_ren !== 1'b0) begin
            fails++; $display("FAIL rstmid_after: got valid=%b data=%h ren=%b want 0/0/0", m_valid, m_data, fifo_ren);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b0) begin
                fails++; $display("FAIL rstmid_stale[%0d]: got %b want 0", c, m_valid);
            end
        end
        @(posedge clk); #1;
        load(32'hB0, 2);
        for (int c = 0; c < 20 && k < 2; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                tests++;
                if (m_data !== 32'hB0 + DW'(k)) begin
                    fails++; $display("FAIL rstmid_data[%0d]: got %h want %h", k, m_data, 32'hB0 + DW'(k));
                end
                k++;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (k != 2) begin
            fails++; $display("FAIL rstmid_count: got %0d want 2", k);
        end
    endtask

    task automatic test_alternating();
        int k = 0, bad_ren = 0;
        do_reset();
        load(32'hC0, 8);
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
            @(negedge clk);
            if (fifo_ren && fifo_empty) bad_ren++;
            if (m_valid && m_ready) begin
                tests++;
                if (m_data !== 32'hC0 + DW'(k)) begin
                    fails++; $display("FAIL alt_data[%0d]: got %h want %h", k, m_data, 32'hC0 + DW'(k));
                end
                k++;
            end
            @(posedge clk); #1;
            m_ready = ~m_ready;
        end
        tests++;
        if (k != 8) begin
            fails++; $display("FAIL alt_count: got %0d want 8", k);
        end
        tests++;
        if (bad_ren != 0) begin
            fails++; $display("FAIL alt_ren_empty: got %0d want 0", bad_ren);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        m_ready = 1'b0;
        wr_ptr  = 0;
        test_reset();
        test_fill_drain();
        test_backpressure();
        test_empty_fifo();
        test_reset_mid();
        test_alternating();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
